demux_1to4_stream: RTL and testbench
====================================

// Module: demux_1to4_stream
// PURPOSE
//  Registered 1-to-4 demultiplexer: routes one input stream to one of four output channels chosen
//  by a 2-bit select. Counterpart of the 4-to-1 mux path. Each channel has a one-entry holding
//  register with a valid/ready handshake and a wrap-around transfer counter. Sits between a
//  single producer and four independent consumers.
// PARAMETERS
//  WIDTH  1  data bits per beat
//  CNT_W  8  width of each per-channel delivered-beat counter
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  rst        in   1          reset, synchronous, active-high
//  flush      in   1          sync clear of all channel registers (counters hold)
//  in_valid   in   1          producer has a beat
//  in_ready   out  1          beat accepted this cycle when in_valid & in_ready
//  in_sel     in   2          destination channel (0..3) of the current beat
//  in_data    in   WIDTH      beat payload
//  out_valid  out  4          per-channel holding register full
//  out_ready  in   4          per-channel consumer ready
//  out_data   out  4*WIDTH    channel i payload at [i*WIDTH +: WIDTH]
//  out_cnt    out  4*CNT_W    channel i delivered beats at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=4'b0000, out_data=0, out_cnt=0. rst beats flush.
//  - in_ready (comb) = ~flush & (~out_valid[in_sel] | out_ready[in_sel]); no dependency on in_valid.
//  - Accept: in_valid & in_ready -> next edge slot[in_sel] <= in_data, out_valid[in_sel] <= 1.
//    Latency 1 cycle input-to-output; no combinational in_data->out_data path.
//  - Drain: out_valid[i] & out_ready[i] -> beat delivered; out_valid[i] <= 0 unless reloaded
//    in the same cycle; out_cnt[i] <= out_cnt[i]+1.
//  - Simultaneous drain + load on same channel: load wins, out_valid stays 1, new data
//    replaces old, counter increments -> sustained 1 beat/cycle per channel.
//  - Loads to channel j never disturb channel i != j (data, valid or counter).
//  - Full channel with out_ready=0: in_ready=0 for beats selected to it; producer must hold
//    in_valid/in_sel/in_data stable until accepted. Other channels keep draining.
//  - out_data[i] stable while out_valid[i]=1 and not drained; value undefined-but-held when invalid
//    (implementation keeps last value).
//  - Counter arithmetic modulo 2^CNT_W: 2^CNT_W-1 + 1 -> 0, no sticky saturation.
//  - flush=1: next edge out_valid <= 0 (data dropped, not counted); in_ready=0 that cycle;
//    beats draining in the flush cycle are counted (handshake completed). Counters hold.
//  - rst mid-operation: everything returns to reset values on the next edge, pending beats lost.
//  - No state machine beyond per-channel EMPTY/FULL (out_valid bit).
// STRUCTURE
//  - Package demux_pkg: NUM_CH=4, SEL_W=2, typedef logic [SEL_W-1:0] ch_sel_t.
//  - Sub-module sel_decoder_2to4: in_sel -> one-hot load enable, gated by accept.
//  - Four identical channel slices (generate loop): holding reg, valid bit, counter.
// TESTING
//  1 rst held 2 cycles -> out_valid=0000, out_cnt all 0, in_ready=1 for any in_sel.
//  2 in_data=1,in_sel=2, out_ready=0100 -> next cycle out_valid=0100, out_data[2]=1;
//    cycle after out_valid=0000, out_cnt[2]=1.
//  3 out_ready[1]=0, two beats sel=1 -> second stalls, in_ready=0; beat to sel=3 meanwhile
//    accepted; raise out_ready[1] -> stalled beat delivered, out_cnt[1]=2.
//  4 out_ready=1111, in_sel cycling 0,1,2,3 for 16 back-to-back beats -> in_ready always 1,
//    out_cnt each =4, data order preserved per channel.
//  5 CNT_W=8, preload 255 beats on ch0 then one more -> out_cnt[0] wraps to 0.
//  6 flush with ch1,ch3 full -> out_valid=0000 next cycle, counters unchanged, in_ready=0
//    during flush; rst asserted mid-stream -> all outputs to reset values next edge.

Source files
------------

// File: rtl/demux_1to4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Channel count and select width live here so every file agrees.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/demux_1to4_stream_if.sv
// Producer-side and consumer-side stream bundle of the demultiplexer.
// master drives beats and consumer readies; slave is the demux itself.
interface demux_1to4_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);

    logic                      in_valid;
    logic                      in_ready;
    ch_sel_t                   in_sel;
    logic [WIDTH-1:0]          in_data;
    logic [NUM_CH-1:0]         out_valid;
    logic [NUM_CH-1:0]         out_ready;
    logic [NUM_CH*WIDTH-1:0]   out_data;
    logic [NUM_CH*CNT_W-1:0]   out_cnt;

    modport master (
        output in_valid,
        output in_sel,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_cnt
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_cnt
    );

endinterface

// File: rtl/demux_1to4_stream_sel_decoder.sv
// Turns the 2-bit channel select into a one-hot load enable.
// All enables stay low unless the beat is actually accepted.
module sel_decoder_2to4
    import demux_pkg::*;
(
    input  ch_sel_t           i_sel,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_load
);

    // One-hot decode of the select, gated by the accept strobe
    always_comb begin
        o_load = '0;
        unique case (i_sel)
            2'd0: o_load[0] = i_en;
            2'd1: o_load[1] = i_en;
            2'd2: o_load[2] = i_en;
            2'd3: o_load[3] = i_en;
        endcase
    end

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-entry holding
// register and a wrap-around delivered-beat counter per channel.
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    demux_1to4_stream_if.slave bus
);

    logic             r_valid [NUM_CH];
    logic [WIDTH-1:0] r_data  [NUM_CH];
    logic [CNT_W-1:0] r_cnt   [NUM_CH];

    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_load;
    logic              w_accept;

    // A channel can take a beat when empty or draining this cycle
    assign bus.in_ready = ~flush
                        & (~w_valid[bus.in_sel]
                           | bus.out_ready[bus.in_sel]);

    assign w_accept = bus.in_valid & bus.in_ready;

    sel_decoder_2to4 u_dec (
        .i_sel  (bus.in_sel),
        .i_en   (w_accept),
        .o_load (w_load)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_drain;

        assign w_drain = r_valid[i] & bus.out_ready[i];

        assign w_valid[i]                    = r_valid[i];
        assign bus.out_valid[i]              = r_valid[i];
        assign bus.out_data[i*WIDTH +: WIDTH] = r_data[i];
        assign bus.out_cnt[i*CNT_W +: CNT_W]  = r_cnt[i];

        // Delivered beats are counted even in a flush cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (w_drain) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end

        // Holding slot: a load beats a drain, a flush beats both
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
            end else if (flush) begin
                r_valid[i] <= 1'b0;
            end else if (w_load[i]) begin
                r_valid[i] <= 1'b1;
                r_data[i]  <= bus.in_data;
            end else if (w_drain) begin
                r_valid[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed self-checking bench for demux_1to4_stream.
// Each scenario task drives its vectors and checks inline.
module tb_demux_1to4_stream;

    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   errors;

    demux_1to4_stream_if #(.WIDTH(1), .CNT_W(8)) bus ();

    demux_1to4_stream #(.WIDTH(1), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 1'b0;
        bus.out_ready = 4'b0000;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid got %b want 0000", bus.out_valid);
        end
        checks++;
        if (bus.out_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", bus.out_cnt);
        end
        checks++;
        if (bus.out_data !== 4'b0000) begin
            errors++;
            $display("FAIL reset_data got %b want 0000", bus.out_data);
        end
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready sel=%0d got %b want 1", s, bus.in_ready);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 1'b1;
        bus.in_sel    = 2'd2;
        bus.out_ready = 4'b0100;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b want 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_data[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_load got v=%b d=%b want v=0100 d2=1", bus.out_valid, bus.out_data);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_cnt[16 +: 8] !== 8'd1) begin
            errors++;
            $display("FAIL single_drain got v=%b c2=%0d want v=0000 c2=1", bus.out_valid, bus.out_cnt[16 +: 8]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 1'b1;
        step();
        bus.in_data = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready got %b want 0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got v=%b d=%b want v=0010 d1=1", bus.out_valid, bus.out_data);
        end
        bus.in_sel  = 2'd3;
        bus.in_data = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_other_ready got %b want 1", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b1010 || bus.out_data !== 4'b1010) begin
            errors++;
            $display("FAIL stall_other got v=%b d=%b want v=1010 d=1010", bus.out_valid, bus.out_data);
        end
        bus.in_sel    = 2'd1;
        bus.in_data   = 1'b0;
        bus.out_ready = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready got %b want 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b1010 || bus.out_data[1] !== 1'b0 || bus.out_cnt[8 +: 8] !== 8'd1) begin
            errors++;
            $display("FAIL stall_reload got v=%b d=%b c1=%0d want v=1010 d1=0 c1=1", bus.out_valid, bus.out_data, bus.out_cnt[8 +: 8]);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b1000 || bus.out_cnt[8 +: 8] !== 8'd2 || bus.out_cnt[24 +: 8] !== 8'd0) begin
            errors++;
            $display("FAIL stall_final got v=%b c1=%0d c3=%0d want v=1000 c1=2 c3=0", bus.out_valid, bus.out_cnt[8 +: 8], bus.out_cnt[24 +: 8]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        int          bad_rdy;
        int          bad_dat;
        pat     = 16'b1011_0110_0101_1100;
        bad_rdy = 0;
        bad_dat = 0;
        do_reset();
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.in_sel  = 2'(k % 4);
            bus.in_data = pat[k];
            #1;
            if (bus.in_ready !== 1'b1) bad_rdy++;
            step();
            if (bus.out_valid[k % 4] !== 1'b1 || bus.out_data[k % 4] !== pat[k]) bad_dat++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL b2b_ready stalls got %0d want 0", bad_rdy);
        end
        checks++;
        if (bad_dat != 0) begin
            errors++;
            $display("FAIL b2b_data wrong beats got %0d want 0", bad_dat);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_cnt !== 32'h04040404) begin
            errors++;
            $display("FAIL b2b_cnt got v=%b c=%h want v=0000 c=04040404", bus.out_valid, bus.out_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 4'b0001;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 1'b1;
        for (int k = 0; k < 255; k++) step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_cnt[0 +: 8] !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255 got %0d want 255", bus.out_cnt[0 +: 8]);
        end
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_cnt !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero got %h want 0", bus.out_cnt);
        end
    endtask

    task automatic test_flush_rst();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        bus.in_sel   = 2'd1;
        step();
        bus.in_sel = 2'd3;
        step();
        checks++;
        if (bus.out_valid !== 4'b1010) begin
            errors++;
            $display("FAIL flush_setup got %b want 1010", bus.out_valid);
        end
        flush         = 1'b1;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b want 0", bus.in_ready);
        end
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_cnt !== 32'h00000100) begin
            errors++;
            $display("FAIL flush_clear got v=%b c=%h want v=0000 c=00000100", bus.out_valid, bus.out_cnt);
        end
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        step();
        bus.in_sel = 2'd0;
        rst        = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_cnt !== 32'h0 || bus.out_data !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst got v=%b d=%b c=%h want all 0", bus.out_valid, bus.out_data, bus.out_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_flush_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
